// File: rtl/threshold_run_detector_pkg.sv
// threshold_run_detector_pkg: shared FSM state type and width helper for the K-of-N run detector.
//   Contents: state_t (IDLE / ARMED / DETECTED), width_for(n) = bits needed to hold 0..n.
package threshold_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DETECTED
    } state_t;

    function automatic int width_for(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/threshold_run_detector_if.sv
// threshold_run_detector_if: sample/control bus and result bus of the run detector.
//   in_val  : sample valid           in     : NBITS sample vector
//   thresh  : hit threshold (CW)     clear  : return to IDLE, zero run
//   count   : popcount of last valid sample (CW)
//   hit     : count >= thresh of last valid sample
//   run     : consecutive-hit count, saturating at RUN_LEN (RW)
//   detect  : high while in DETECTED
//   master drives samples/control, slave (the detector) drives results.
interface threshold_run_detector_if
    import threshold_run_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int RUN_LEN = 3
);

    localparam int CW = width_for(NBITS);
    localparam int RW = width_for(RUN_LEN);

    logic             in_val;
    logic [NBITS-1:0] in;
    logic [CW-1:0]    thresh;
    logic             clear;
    logic [CW-1:0]    count;
    logic             hit;
    logic [RW-1:0]    run;
    logic             detect;

    modport master (
        output in_val, in, thresh, clear,
        input  count, hit, run, detect
    );

    modport slave (
        input  in_val, in, thresh, clear,
        output count, hit, run, detect
    );

endinterface

// File: rtl/threshold_run_detector_popcount.sv
// popcount: combinational count of set bits in an NBITS-wide vector.
//   in_i    : NBITS input vector
//   count_o : number of ones in in_i, width $clog2(NBITS+1)
module popcount
    import threshold_run_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic [NBITS-1:0]             in_i,
    output logic [width_for(NBITS)-1:0]  count_o
);

    localparam int CW = width_for(NBITS);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < NBITS; i++)
            count_o = count_o + CW'(in_i[i]);
    end

endmodule

// File: rtl/threshold_run_detector.sv
// threshold_run_detector: K-of-N detector flagging RUN_LEN consecutive valid samples with popcount >= thresh.
//   clk    : clock
//   reset  : synchronous, active-low reset
//   bus    : slave side of threshold_run_detector_if (samples in, count/hit/run/detect out)
module threshold_run_detector
    import threshold_run_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int RUN_LEN = 3
) (
    input logic                   clk,
    input logic                   reset,
    threshold_run_detector_if.slave bus
);

    localparam int CW = width_for(NBITS);
    localparam int RW = width_for(RUN_LEN);

    logic [CW-1:0] pop;
    logic          hit_now;
    logic [RW:0]   run_inc;
    logic [CW-1:0] count_q, count_d;
    logic          hit_q, hit_d;
    logic [RW-1:0] run_q, run_d;
    state_t        state_q, state_d;

    popcount #(.NBITS(NBITS)) u_popcount (
        .in_i    (bus.in),
        .count_o (pop)
    );

    assign hit_now = pop >= bus.thresh;
    // One extra bit so run+1 can be compared against RUN_LEN without wrapping.
    assign run_inc = {1'b0, run_q} + (RW+1)'(1);

    // Datapath next state; clear zeroes the run but a coincident sample still updates count/hit.
    always_comb begin
        count_d = bus.in_val ? pop : count_q;
        hit_d   = bus.in_val ? hit_now : hit_q;
        run_d   = bus.clear   ? '0 :
                  !bus.in_val ? run_q :
                  !hit_now    ? '0 :
                  (run_inc > (RW+1)'(RUN_LEN)) ? RW'(RUN_LEN) : run_inc[RW-1:0];
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear)
            state_d = ST_IDLE;
        else if (bus.in_val)
            case (state_q)
                ST_IDLE:  if (hit_now) state_d = (RUN_LEN == 1) ? ST_DETECTED : ST_ARMED;
                ST_ARMED: if (!hit_now) state_d = ST_IDLE;
                          else if (run_inc == (RW+1)'(RUN_LEN)) state_d = ST_DETECTED;
                default:  state_d = state_q;
            endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hit_q   <= 1'b0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hit_q   <= hit_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        bus.count  = count_q;
        bus.hit    = hit_q;
        bus.run    = run_q;
        bus.detect = state_q == ST_DETECTED;
    end

endmodule

// File: tb/tb_threshold_run_detector.sv
// tb_threshold_run_detector: directed scoreboard bench for the 8-bit/RUN_LEN=3 detector and a 3-bit majority instance.
module tb_threshold_run_detector;

    typedef struct packed {
        logic [3:0] count;
        logic       hit;
        logic [1:0] run;
        logic       detect;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t  exp_q[$];
    string tag_q[$];
    logic [7:0] maj = 8'hE8;

    always #5 clk = ~clk;

    threshold_run_detector_if #(.NBITS(8), .RUN_LEN(3)) a ();
    threshold_run_detector_if #(.NBITS(3), .RUN_LEN(1)) b ();

    threshold_run_detector #(.NBITS(8), .RUN_LEN(3)) dut_a (.clk(clk), .reset(reset), .bus(a));
    threshold_run_detector #(.NBITS(3), .RUN_LEN(1)) dut_b (.clk(clk), .reset(reset), .bus(b));

    task automatic check_a();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        assert (a.count === e.count) else begin
            miscompares++;
            $error("FAIL %s count: got %0d expected %0d", t, a.count, e.count);
        end
        vectors++;
        assert (a.hit === e.hit) else begin
            miscompares++;
            $error("FAIL %s hit: got %b expected %b", t, a.hit, e.hit);
        end
        vectors++;
        assert (a.run === e.run) else begin
            miscompares++;
            $error("FAIL %s run: got %0d expected %0d", t, a.run, e.run);
        end
        vectors++;
        assert (a.detect === e.detect) else begin
            miscompares++;
            $error("FAIL %s detect: got %b expected %b", t, a.detect, e.detect);
        end
    endtask

    task automatic step(input logic rst_n, input logic v, input logic clr,
                        input logic [7:0] d, input logic [3:0] th,
                        input logic [3:0] ec, input logic eh, input logic [1:0] er,
                        input logic ed, input string tag);
        reset    = rst_n;
        a.in_val = v;
        a.clear  = clr;
        a.in     = d;
        a.thresh = th;
        exp_q.push_back('{ec, eh, er, ed});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_a();
    endtask

    initial begin
        b.in_val = 1'b0;
        b.clear  = 1'b0;
        b.in     = '0;
        b.thresh = 2'd2;
        // reset held with a valid all-ones sample
        step(0, 1, 0, 8'hFF, 4'd2, 0, 0, 0, 0, "reset0");
        step(0, 1, 0, 8'hFF, 4'd2, 0, 0, 0, 0, "reset1");
        // threshold edges
        step(1, 1, 0, 8'h01, 4'd2, 1, 0, 0, 0, "thr_below");
        step(1, 1, 0, 8'h81, 4'd2, 2, 1, 1, 0, "thr_equal");
        step(1, 1, 0, 8'hFF, 4'd2, 8, 1, 2, 0, "thr_full");
        step(1, 1, 0, 8'h00, 4'd0, 0, 1, 3, 1, "thr_zero");
        step(1, 0, 1, 8'h00, 4'd2, 0, 1, 0, 0, "clr_gap");
        step(1, 1, 0, 8'hFF, 4'd9, 8, 0, 0, 0, "thr_over");
        // run build-up and sticky detect
        step(1, 1, 0, 8'h03, 4'd2, 2, 1, 1, 0, "run1");
        step(1, 1, 0, 8'h07, 4'd2, 3, 1, 2, 0, "run2");
        step(1, 1, 0, 8'h0F, 4'd2, 4, 1, 3, 1, "run3");
        step(1, 1, 0, 8'h00, 4'd2, 0, 0, 0, 1, "sticky_miss");
        step(1, 0, 0, 8'hFF, 4'd0, 0, 0, 0, 1, "gap0");
        step(1, 0, 0, 8'h5A, 4'd0, 0, 0, 0, 1, "gap1");
        step(1, 0, 1, 8'h00, 4'd2, 0, 0, 0, 0, "clr_idle");
        // broken run
        step(1, 1, 0, 8'h03, 4'd2, 2, 1, 1, 0, "brk1");
        step(1, 1, 0, 8'h03, 4'd2, 2, 1, 2, 0, "brk2");
        step(1, 1, 0, 8'h00, 4'd2, 0, 0, 0, 0, "brk_miss");
        step(1, 1, 0, 8'h03, 4'd2, 2, 1, 1, 0, "brk3");
        step(1, 1, 0, 8'h03, 4'd2, 2, 1, 2, 0, "brk4");
        step(1, 1, 0, 8'h03, 4'd2, 2, 1, 3, 1, "brk5");
        step(1, 1, 0, 8'h0F, 4'd2, 4, 1, 3, 1, "sat");
        // clear with a coincident valid sample
        step(1, 1, 1, 8'hFF, 4'd2, 8, 1, 0, 0, "clr_val");
        step(1, 1, 0, 8'h03, 4'd2, 2, 1, 1, 0, "post_clr");
        step(1, 1, 0, 8'h03, 4'd2, 2, 1, 2, 0, "pre_rst");
        // reset mid-run discards progress and beats clear
        step(0, 1, 1, 8'hFF, 4'd2, 0, 0, 0, 0, "rst_mid");
        step(1, 1, 0, 8'h03, 4'd2, 2, 1, 1, 0, "post_rst");
        a.in_val = 1'b0;
        a.clear  = 1'b0;
        // 2-of-3 majority on the RUN_LEN=1 instance
        for (int i = 0; i < 8; i++) begin
            b.clear  = 1'b1;
            b.in_val = 1'b0;
            @(posedge clk);
            #1;
            b.clear  = 1'b0;
            b.in_val = 1'b1;
            b.in     = 3'(i);
            @(posedge clk);
            #1;
            b.in_val = 1'b0;
            vectors++;
            assert (b.detect === maj[i]) else begin
                miscompares++;
                $error("FAIL maj%0d detect: got %b expected %b", i, b.detect, maj[i]);
            end
            vectors++;
            assert (b.run === maj[i]) else begin
                miscompares++;
                $error("FAIL maj%0d run: got %0d expected %0d", i, b.run, maj[i]);
            end
            vectors++;
            assert (b.count === 2'($countones(i))) else begin
                miscompares++;
                $error("FAIL maj%0d count: got %0d expected %0d", i, b.count, $countones(i));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
